bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares one synchronous-read memory port between several bus masters (CPU instruction/data bus, loader, DMA) using the same word-addressed, byte-masked bus the CPU drives. Grants are combinational in the request cycle, so a granted master sees read data one cycle later, exactly as with a directly attached memory. Arbitration is round-robin with an optional per-port lock for short atomic bursts, bounded by a hold limit to prevent starvation.

## Interface
- PORTS, 2, number of masters (2..8)
- MAX_HOLD, 8, max consecutive locked grants to one port while another port is requesting (>=1)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  PORTS  master i requests the bus this cycle
- lock  in  PORTS  master i asks to keep the bus after this access
- addr  in  PORTS*30  word address, port i in bits [30*i+29:30*i]
- data_w  in  PORTS*32  write data, port i in bits [32*i+31:32*i]
- mask_w  in  PORTS*4  byte write enables; all zero means read
- gnt  out  PORTS  one-hot or zero; combinational
- rvalid  out  PORTS  registered; read data for port i is valid this cycle
- data_r  out  32  read data broadcast to all masters (= mem_data_r)
- mem_addr  out  30  memory word address; combinational
- mem_data_w  out  32  memory write data; combinational
- mem_mask_w  out  4  memory byte enables; combinational
- mem_data_r  in  32  memory read data, valid one cycle after the address

## Operation
- State: last (index of last granted port), owner_valid, owner (index), hold (counter, 0..MAX_HOLD, saturating).
- Lock continuation: if owner_valid & req[owner] & lock[owner] & (hold < MAX_HOLD or no other req), grant owner.
- Otherwise round-robin: grant the first requesting port scanning last+1, last+2, ... modulo PORTS, including last itself at the end.
- No req: gnt = 0, mem_addr = 0, mem_data_w = 0, mem_mask_w = 0.
- Granted port g: mem_addr/mem_data_w/mem_mask_w = port g's fields; a write commits at the clock edge closing the grant cycle.
- Registered updates on grant to g: last <= g; owner <= g; owner_valid <= lock[g]; hold <= (owner_valid & owner == g) ? min(hold+1, MAX_HOLD) : 1.
- No grant: owner_valid <= 0, hold <= 0; last unchanged.
- rvalid[i] <= gnt[i] & (mask_w[i] == 0); writes never produce rvalid.
- data_r is mem_data_r passed through unmodified; masters qualify it with their rvalid.
- A master not granted must hold req, addr, data_w and mask_w stable until granted; the arbiter keeps no request queue.

## Timing
- Reset asserted (asynchronous): last = PORTS-1, owner_valid = 0, hold = 0, rvalid = 0; while reset is high gnt = 0, mem_mask_w = 0, mem_addr = 0, mem_data_w = 0 regardless of req.
- First cycle after reset release with all ports requesting: port 0 wins.
- Grant latency: 0 cycles (same cycle as req). Read data latency: 1 cycle (rvalid and data_r in the next cycle).
- Back-to-back grants to different ports every cycle are legal; rvalid for cycle n's read appears in cycle n+1, independent of the grant in cycle n+1.
- Hold limit: a locked port with a competitor is granted at most MAX_HOLD consecutive cycles. The next cycle goes round-robin, which selects the competitor first.
- Locked port with no competitor: continues indefinitely, hold saturates at MAX_HOLD.
- Lock dropped or req dropped by the owner: ownership ends; arbitration reverts to round-robin in the same cycle.
- Reset mid-read: rvalid for the pending read is cleared; the data is lost and masters reissue.
- Single-port requests: always granted immediately, even when last == that port.

## Test plan
- Reset then req = 2'b11, both reads: gnt = 01, next cycle gnt = 10; rvalid = 01 then 10 with data_r = mem contents at each addr.
- Port 1 alone writes addr 5, data 0xDEADBEEF, mask 1111; then port 0 reads addr 5: gnt immediate both times, rvalid[0] = 1 next cycle, data_r = 0xDEADBEEF, rvalid[1] never set.
- Port 0 req+lock held, port 1 req held, MAX_HOLD = 8: gnt[0] for 8 consecutive cycles, then gnt[1] in cycle 9.
- Port 0 req+lock with port 1 idle for 20 cycles: gnt[0] every cycle, hold saturates at 8; port 1 then requests: granted next cycle.
- PORTS = 3, all requesting continuously without lock: grant sequence 0,1,2,0,1,2; drop req[1]: sequence 0,2,0,2.
- Assert reset during a granted read cycle: gnt = 0 and mem_mask_w = 0 immediately, rvalid = 0 next cycle; after release port 0 wins first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port between PORTS bus masters.
// Grants are combinational; a locked owner may keep the bus for up to MAX_HOLD cycles under contention.
module bus_arbiter #(
  parameter int PORTS    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PORTS-1:0]    req,
  input  logic [PORTS-1:0]    lock,
  input  logic [PORTS*30-1:0] addr,
  input  logic [PORTS*32-1:0] data_w,
  input  logic [PORTS*4-1:0]  mask_w,
  output logic [PORTS-1:0]    gnt,
  output logic [PORTS-1:0]    rvalid,
  output logic [31:0]         data_r,
  output logic [29:0]         mem_addr,
  output logic [31:0]         mem_data_w,
  output logic [3:0]          mem_mask_w,
  input  logic [31:0]         mem_data_r
);
  localparam int IW = $clog2(PORTS);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(PORTS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             owner_valid_q, owner_valid_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PORTS-1:0] rvalid_q, rvalid_d;

  logic [PORTS-1:0] others;
  logic             other_req;
  logic             keep_owner;
  logic             gnt_any;
  logic [IW-1:0]    gnt_idx;

  // Requests from anyone other than the current owner decide whether the hold limit applies.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_others
    assign others[gi] = req[gi] && (owner_q != IW'(gi));
  end
  assign other_req = |others;

  always_comb begin
    int cand;
    cand       = 0;
    keep_owner = owner_valid_q && req[owner_q] && lock[owner_q] &&
                 ((hold_q < HOLD_MAX) || !other_req);
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    if (!reset) begin
      if (keep_owner) begin
        gnt_any = 1'b1;
        gnt_idx = owner_q;
      end else begin
        // Scan starts just after the last winner and ends on the last winner itself.
        for (int k = 1; k <= PORTS; k++) begin
          cand = (int'(last_q) + k) % PORTS;
          if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(cand);
          end
        end
      end
    end
  end

  always_comb begin
    gnt        = '0;
    mem_addr   = '0;
    mem_data_w = '0;
    mem_mask_w = '0;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
      mem_addr     = addr[30*int'(gnt_idx) +: 30];
      mem_data_w   = data_w[32*int'(gnt_idx) +: 32];
      mem_mask_w   = mask_w[4*int'(gnt_idx) +: 4];
    end
  end

  always_comb begin
    last_d        = last_q;
    owner_d       = owner_q;
    owner_valid_d = 1'b0;
    hold_d        = '0;
    rvalid_d      = '0;
    if (gnt_any) begin
      last_d        = gnt_idx;
      owner_d       = gnt_idx;
      owner_valid_d = lock[gnt_idx];
      if (owner_valid_q && (owner_q == gnt_idx))
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      else
        hold_d = HW'(1);
      rvalid_d[gnt_idx] = (mem_mask_w == 4'b0000);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q        <= LAST_INIT;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      hold_q        <= '0;
      rvalid_q      <= '0;
    end else begin
      last_q        <= last_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      hold_q        <= hold_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign data_r = mem_data_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (3 ports, hold limit 8): a rule-level arbiter model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter;
  localparam int P  = 3;
  localparam int MH = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [P-1:0]    req, lock, gnt, rvalid;
  logic [P*30-1:0] addr;
  logic [P*32-1:0] data_w;
  logic [P*4-1:0]  mask_w;
  logic [31:0]     data_r, mem_data_w, mem_data_r, mem_rd;
  logic [29:0]     mem_addr;
  logic [3:0]      mem_mask_w;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.PORTS(P), .MAX_HOLD(MH)) dut (
    .clock(clock), .reset(reset), .req(req), .lock(lock), .addr(addr),
    .data_w(data_w), .mask_w(mask_w), .gnt(gnt), .rvalid(rvalid), .data_r(data_r),
    .mem_addr(mem_addr), .mem_data_w(mem_data_w), .mem_mask_w(mem_mask_w),
    .mem_data_r(mem_data_r)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory attached to the shared port.
  logic [31:0] mem [0:63];
  always @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (mem_mask_w[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_data_w[8*b +: 8];
    mem_rd <= mem[mem_addr[5:0]];
  end
  assign mem_data_r = mem_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:63];
  int          m_last = P - 1, m_owner = 0, m_hold = 0;
  bit          m_ov = 1'b0;
  logic [P-1:0] m_rvalid = '0;
  logic [31:0] m_rdata = '0;
  int          n_last, n_owner, n_hold;
  bit          n_ov;
  logic [P-1:0] n_rvalid;
  logic [31:0] n_rdata, n_wdata;
  logic [5:0]  n_waddr;
  logic [3:0]  n_wmask = '0;

  function automatic int pick();
    int contenders = 0;
    for (int i = 0; i < P; i++)
      if (req[i] && i != m_owner) contenders++;
    if (m_ov && req[m_owner] && lock[m_owner] && (m_hold < MH || contenders == 0))
      return m_owner;
    for (int k = 1; k <= P; k++)
      if (req[(m_last + k) % P]) return (m_last + k) % P;
    return -1;
  endfunction

  initial forever begin
    int g;
    logic [31:0] eg, ed;
    logic [29:0] ea;
    logic [3:0]  em;
    @(negedge clock);
    g  = reset ? -1 : pick();
    eg = '0; ea = '0; ed = '0; em = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ea = addr[30*g +: 30];
      ed = data_w[32*g +: 32];
      em = mask_w[4*g +: 4];
    end
    chk("model_gnt", {29'd0, gnt}, eg);
    chk("model_mem_addr", {2'd0, mem_addr}, {2'd0, ea});
    chk("model_mem_data_w", mem_data_w, ed);
    chk("model_mem_mask_w", {28'd0, mem_mask_w}, {28'd0, em});
    chk("model_rvalid", {29'd0, rvalid}, reset ? 32'd0 : {29'd0, m_rvalid});
    if (!reset && m_rvalid != 0) chk("model_data_r", data_r, m_rdata);
    n_last = m_last; n_owner = m_owner; n_ov = 1'b0; n_hold = 0;
    n_rvalid = '0; n_rdata = m_rdata; n_wmask = '0; n_waddr = '0; n_wdata = '0;
    if (g >= 0) begin
      n_last  = g;
      n_owner = g;
      n_ov    = lock[g];
      n_hold  = (m_ov && m_owner == g) ? ((m_hold + 1 > MH) ? MH : m_hold + 1) : 1;
      if (em == 4'b0000) begin
        n_rvalid[g] = 1'b1;
        n_rdata     = ref_mem[ea[5:0]];
      end
      n_wmask = em; n_waddr = ea[5:0]; n_wdata = ed;
    end
  end

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_last = P - 1; m_owner = 0; m_ov = 1'b0; m_hold = 0; m_rvalid = '0;
    end else begin
      m_last = n_last; m_owner = n_owner; m_ov = n_ov; m_hold = n_hold;
      m_rvalid = n_rvalid; m_rdata = n_rdata;
      for (int b = 0; b < 4; b++)
        if (n_wmask[b]) ref_mem[n_waddr][8*b +: 8] = n_wdata[8*b +: 8];
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic setp(input int p, input bit r, input bit l, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] m);
    req[p] = r; lock[p] = l;
    addr[30*p +: 30] = a; data_w[32*p +: 32] = d; mask_w[4*p +: 4] = m;
  endtask

  task automatic clear_all();
    req = '0; lock = '0; addr = '0; data_w = '0; mask_w = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    next_cycle(); reset = 1'b1; clear_all();
    next_cycle(); reset = 1'b0;
  endtask

  int seq_all [6] = '{0, 1, 2, 0, 1, 2};
  int seq_02  [4] = '{0, 2, 0, 2};

  initial begin
    clear_all();
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA000_0000 + i;
      ref_mem[i] = 32'hA000_0000 + i;
    end
    sample();
    chk("reset_gnt", {29'd0, gnt}, 32'd0);
    chk("reset_rvalid", {29'd0, rvalid}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Two simultaneous reads after reset: port 0 first, then port 1.
    setp(0, 1, 0, 30'd3, 32'd0, 4'h0); setp(1, 1, 0, 30'd7, 32'd0, 4'h0);
    sample(); chk("t1_gnt_first", {29'd0, gnt}, 32'd1); chk("t1_rvalid_none", {29'd0, rvalid}, 32'd0);
    next_cycle(); setp(0, 0, 0, 30'd0, 32'd0, 4'h0);
    sample(); chk("t1_gnt_second", {29'd0, gnt}, 32'd2); chk("t1_rvalid0", {29'd0, rvalid}, 32'd1);
    chk("t1_data0", data_r, 32'hA000_0003);
    next_cycle(); clear_all();
    sample(); chk("t1_gnt_idle", {29'd0, gnt}, 32'd0); chk("t1_rvalid1", {29'd0, rvalid}, 32'd2);
    chk("t1_data1", data_r, 32'hA000_0007);

    // Port 1 writes, port 0 reads the same word back.
    next_cycle(); setp(1, 1, 0, 30'd5, 32'hDEAD_BEEF, 4'hF);
    sample(); chk("t2_wr_gnt", {29'd0, gnt}, 32'd2); chk("t2_wr_addr", {2'd0, mem_addr}, 32'd5);
    chk("t2_wr_data", mem_data_w, 32'hDEAD_BEEF); chk("t2_wr_mask", {28'd0, mem_mask_w}, 32'hF);
    next_cycle(); setp(1, 0, 0, 30'd0, 32'd0, 4'h0); setp(0, 1, 0, 30'd5, 32'd0, 4'h0);
    sample(); chk("t2_rd_gnt", {29'd0, gnt}, 32'd1); chk("t2_no_wr_rvalid", {29'd0, rvalid}, 32'd0);
    next_cycle(); clear_all();
    sample(); chk("t2_rd_rvalid", {29'd0, rvalid}, 32'd1); chk("t2_rd_data", data_r, 32'hDEAD_BEEF);

    // Locked port 0 against a waiting port 1: eight grants, then the competitor.
    do_reset();
    setp(0, 1, 1, 30'd1, 32'd0, 4'h0); setp(1, 1, 0, 30'd2, 32'd0, 4'h0);
    for (int n = 0; n < MH; n++) begin
      sample(); chk("t3_locked_gnt", {29'd0, gnt}, 32'd1); next_cycle();
    end
    sample(); chk("t3_competitor_gnt", {29'd0, gnt}, 32'd2);
    next_cycle(); clear_all();

    // Locked port 0 alone for 20 cycles, then port 1 arrives.
    setp(0, 1, 1, 30'd4, 32'd0, 4'h0);
    for (int n = 0; n < 20; n++) begin
      sample(); chk("t4_alone_gnt", {29'd0, gnt}, 32'd1); next_cycle();
    end
    setp(1, 1, 0, 30'd6, 32'd0, 4'h0);
    sample(); chk("t4_late_competitor", {29'd0, gnt}, 32'd2);
    next_cycle(); clear_all();

    // Three unlocked requesters rotate; then port 1 drops out.
    do_reset();
    for (int p = 0; p < P; p++) setp(p, 1, 0, 30'(10 + p), 32'd0, 4'h0);
    for (int n = 0; n < 6; n++) begin
      sample(); chk("t5_rr_all", {29'd0, gnt}, 32'd1 << seq_all[n]); next_cycle();
    end
    setp(1, 0, 0, 30'd0, 32'd0, 4'h0);
    for (int n = 0; n < 4; n++) begin
      sample(); chk("t5_rr_02", {29'd0, gnt}, 32'd1 << seq_02[n]); next_cycle();
    end

    // Reset lands in the middle of a granted read.
    clear_all(); setp(0, 1, 0, 30'd9, 32'd0, 4'h0);
    sample(); chk("t6_pre_gnt", {29'd0, gnt}, 32'd1);
    #1 reset = 1'b1; setp(1, 1, 0, 30'd11, 32'h1234_5678, 4'hF);
    #1 chk("t6_gnt_in_reset", {29'd0, gnt}, 32'd0);
    chk("t6_mask_in_reset", {28'd0, mem_mask_w}, 32'd0);
    chk("t6_addr_in_reset", {2'd0, mem_addr}, 32'd0);
    next_cycle();
    sample(); chk("t6_rvalid_cleared", {29'd0, rvalid}, 32'd0);
    next_cycle(); reset = 1'b0;
    for (int p = 0; p < P; p++) setp(p, 1, 0, 30'(20 + p), 32'd0, 4'h0);
    sample(); chk("t6_port0_first", {29'd0, gnt}, 32'd1);
    next_cycle(); clear_all();
    sample(); chk("t6_rvalid_after", {29'd0, rvalid}, 32'd1); chk("t6_data_after", data_r, 32'hA000_0014);
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
